// File: rtl/seg_serial_tx_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//   Shared types and constants for the seven-segment serial transmitter.
//   SEG_FRAME_W : bits per display frame (8 digits x 8 segments)
//   SEG_DIV_W   : width of the shift-clock divider counter
//   seg_tx_state_t : transmitter FSM states
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_DIGITS  = 8;
    localparam int SEG_FRAME_W = SEG_DIGITS * 8;
    localparam int SEG_DIV_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } seg_tx_state_t;

endpackage

// File: rtl/seg_serial_tx_if.sv
// ----------------------------------------------------------------------------
// seg_serial_tx_if
//   Frame handshake between the segment encoder (master) and the serial
//   transmitter (slave).
//   start    : master -> slave, frame request
//   seg_data : master -> slave, frame contents, digit 0 in [7:0]
//   busy     : slave -> master, transmitter owns the chain
//   done     : slave -> master, one-cycle pulse when the frame is latched
// ----------------------------------------------------------------------------
interface seg_serial_tx_if
    import seg_pkg::*;
#(
    parameter int FRAME_W = SEG_FRAME_W
);

    logic               start;
    logic [FRAME_W-1:0] seg_data;
    logic               busy;
    logic               done;

    modport master (
        output start,
        output seg_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  seg_data,
        output busy,
        output done
    );

endinterface

// File: rtl/seg_serial_tx_clk_div.sv
// ----------------------------------------------------------------------------
// seg_clk_div
//   Shift-clock phase generator. Counts CLK_DIV clk cycles per seg_clk
//   half-period and reports a tick on the last cycle of each half-period.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   en    : count enable (asserted while shifting)
//   load  : frame load edge; restarts at the beginning of a low phase
//   tick  : last cycle of the current half-period (combinational)
//   phase : 0 = seg_clk low half, 1 = seg_clk high half
// ----------------------------------------------------------------------------
module seg_clk_div
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    output logic tick,
    output logic phase
);

    localparam logic [SEG_DIV_W-1:0] RELOAD = SEG_DIV_W'(CLK_DIV - 1);

    logic [SEG_DIV_W-1:0] cnt;

    // Down-counter: reloads at CLK_DIV-1 and ticks on zero, so a half-period
    // spans exactly CLK_DIV enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (load) begin
            cnt   <= RELOAD;
            phase <= 1'b0;
        end else if (en) begin
            if (cnt == '0) begin
                cnt   <= RELOAD;
                phase <= ~phase;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/seg_serial_tx.sv
// ----------------------------------------------------------------------------
// seg_serial_tx
//   Shifts a 64-bit seven-segment frame MSB first into a 74HC595-style chain
//   and strobes the display enable once the whole frame is in place.
//
//   Parameters
//     FRAME_W     : frame width (fixed at 64)
//     CLK_DIV     : clk cycles per seg_clk half-period, 1..255
//     REFRESH_GAP : idle cycles between automatic frames
//
//   Ports
//     clk      : system clock
//     rst      : synchronous active-high reset
//     bus      : slave side of the start/seg_data/busy/done handshake
//     seg_clk  : shift clock, chain samples on its rising edge
//     seg_sout : serial data
//     seg_pen  : display output enable, active high
//     seg_clrn : chain clear, active low
//
//   Build option
//     SEG_AUTO_REFRESH_EN : when defined, an idle counter starts a frame by
//                           itself every REFRESH_GAP idle cycles.
// ----------------------------------------------------------------------------
module seg_serial_tx
    import seg_pkg::*;
#(
    parameter int FRAME_W     = SEG_FRAME_W,
    parameter int CLK_DIV     = 2,
    parameter int REFRESH_GAP = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_serial_tx_if.slave       bus,
    output logic                 seg_clk,
    output logic                 seg_sout,
    output logic                 seg_pen,
    output logic                 seg_clrn
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("seg_serial_tx: CLK_DIV must be 1..255");
    end
    if (REFRESH_GAP < 1) begin : g_bad_gap
        $error("seg_serial_tx: REFRESH_GAP must be at least 1");
    end
    if (FRAME_W != SEG_FRAME_W) begin : g_bad_frame
        $error("seg_serial_tx: FRAME_W is fixed at 64");
    end

    localparam logic [6:0] LAST_BIT = 7'(FRAME_W - 1);

    seg_tx_state_t      state;
    logic [FRAME_W-1:0] shreg;
    logic [6:0]         bit_cnt;
    logic               busy_r;
    logic               done_r;
    logic               go;
    logic               load;
    logic               tick;
    logic               phase;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

    logic [GAP_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (load) begin
            idle_cnt <= '0;
        end else if (state == IDLE) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        go = bus.start || (idle_cnt == GAP_W'(REFRESH_GAP - 1));
    end
`else
    always_comb begin
        go = bus.start;
    end
`endif

    always_comb begin
        load = (state == IDLE) && go;
    end

    seg_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state == SHIFT),
        .load  (load),
        .tick  (tick),
        .phase (phase)
    );

    // The chain clear simply follows reset one edge late.
    always_ff @(posedge clk) begin
        seg_clrn <= ~rst;
    end

    // shreg holds the bits still to be sent after the one on seg_sout, so
    // the MSB of shreg is always the next bit to present.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            seg_pen  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= SHIFT;
                        shreg    <= {bus.seg_data[FRAME_W-2:0], 1'b0};
                        seg_sout <= bus.seg_data[FRAME_W-1];
                        bit_cnt  <= '0;
                        seg_clk  <= 1'b0;
                        seg_pen  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            seg_clk <= 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            state   <= LATCH;
                            seg_clk <= 1'b0;
                            done_r  <= 1'b1;
                            seg_pen <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            seg_sout <= shreg[FRAME_W-1];
                            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                            seg_clk  <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_seg_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_seg_serial_tx
//   Self-checking bench for seg_serial_tx. Expected serial bits are the frame
//   read MSB to LSB; expected timing is derived from 128*CLK_DIV edges per
//   frame plus one LATCH cycle.
// ----------------------------------------------------------------------------
module tb_seg_serial_tx;

    localparam int CLK_DIV = 2;
    localparam int GAP     = 20;
    localparam int T_DONE  = 128 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;
    logic seg_clk, seg_sout, seg_pen, seg_clrn;

    int checks = 0;
    int errors = 0;

    logic cap_q[$];

    int   obs_done_k, obs_n_done, obs_pen_early, obs_busy_drop_k;
    logic obs_pen_at_done, obs_busy_at_load, obs_pen_at_load;

    seg_serial_tx_if bus ();

    seg_serial_tx #(
        .CLK_DIV     (CLK_DIV),
        .REFRESH_GAP (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .seg_clk  (seg_clk),
        .seg_sout (seg_sout),
        .seg_pen  (seg_pen),
        .seg_clrn (seg_clrn)
    );

    always #5 clk = ~clk;

    // What the chain would see: one bit per rising seg_clk.
    always @(posedge seg_clk) cap_q.push_back(seg_sout);

    function automatic int count_bit_errs(input logic [63:0] frame, input int base);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (base + i >= cap_q.size()) bad++;
            else if (cap_q[base + i] !== frame[63 - i]) bad++;
        end
        return bad;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Starts a frame from IDLE and watches it for T_DONE+2 edges.
    task automatic drive_frame(input logic [63:0] frame, input int restart_k,
                               input logic [63:0] restart_data, input int flip_k);
        cap_q.delete();
        obs_done_k = -1; obs_n_done = 0; obs_pen_early = 0;
        obs_busy_drop_k = -1; obs_pen_at_done = 1'b0;
        bus.seg_data = frame;
        bus.start = 1'b1;
        @(negedge clk);
        obs_busy_at_load = bus.busy;
        obs_pen_at_load = seg_pen;
        for (int k = 1; k <= T_DONE + 2; k++) begin
            bus.start = (k == restart_k);
            if (k == restart_k) bus.seg_data = restart_data;
            if (k == flip_k) bus.seg_data = ~frame;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                obs_n_done++;
                if (obs_done_k < 0) obs_done_k = k;
            end
            if (k < T_DONE && seg_pen !== 1'b0) obs_pen_early++;
            if (k == T_DONE) obs_pen_at_done = seg_pen;
            if (bus.busy === 1'b0 && obs_busy_drop_k < 0) obs_busy_drop_k = k;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seg_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, seg_clk, seg_sout, seg_pen, seg_clrn} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy,done,clk,sout,pen,clrn=%b expected 000000",
                     {bus.busy, bus.done, seg_clk, seg_sout, seg_pen, seg_clrn});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (seg_clrn !== 1'b1) begin
            errors++;
            $display("FAIL reset_clrn_release got %b expected 1", seg_clrn);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || seg_pen !== 1'b0 || seg_clk !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_single_frame(input logic [63:0] frame);
        int bad;
        drive_frame(frame, -1, '0, -1);
        bad = count_bit_errs(frame, 0);
        checks++;
        if (bad != 0 || cap_q.size() != 64) begin
            errors++;
            $display("FAIL frame_bits got %0d bad bits of %0d captured expected 0 of 64 (frame %h)",
                     bad, cap_q.size(), frame);
        end
        checks++;
        if (obs_done_k != T_DONE || obs_n_done != 1) begin
            errors++;
            $display("FAIL frame_done got k=%0d count=%0d expected k=%0d count=1",
                     obs_done_k, obs_n_done, T_DONE);
        end
        checks++;
        if (obs_busy_at_load !== 1'b1 || obs_busy_drop_k != T_DONE + 1) begin
            errors++;
            $display("FAIL frame_busy got load=%b drop=%0d expected load=1 drop=%0d",
                     obs_busy_at_load, obs_busy_drop_k, T_DONE + 1);
        end
        checks++;
        if (obs_pen_at_load !== 1'b0 || obs_pen_early != 0 || obs_pen_at_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_pen got load=%b early=%0d latch=%b expected 0 0 1",
                     obs_pen_at_load, obs_pen_early, obs_pen_at_done);
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] frame = rand64();
        int bad;
        drive_frame(frame, 40, ~frame, -1);
        bad = count_bit_errs(frame, 0);
        checks++;
        if (bad != 0 || cap_q.size() != 64) begin
            errors++;
            $display("FAIL busy_start_bits got %0d bad of %0d expected 0 of 64", bad, cap_q.size());
        end
        checks++;
        if (obs_n_done != 1 || obs_done_k != T_DONE) begin
            errors++;
            $display("FAIL busy_start_done got count=%0d k=%0d expected 1 at %0d",
                     obs_n_done, obs_done_k, T_DONE);
        end
    endtask

    task automatic test_data_change();
        logic [63:0] frame = rand64();
        int bad;
        drive_frame(frame, -1, '0, 10);
        bad = count_bit_errs(frame, 0);
        checks++;
        if (bad != 0 || cap_q.size() != 64) begin
            errors++;
            $display("FAIL data_change_bits got %0d bad of %0d expected 0 of 64", bad, cap_q.size());
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [63:0] frame = rand64();
        int n_done = 0;
        int bad;
        bus.seg_data = frame;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, seg_clk, seg_pen, seg_clrn} !== 5'b0) begin
            errors++;
            $display("FAIL abort_outputs got busy,done,clk,pen,clrn=%b expected 00000",
                     {bus.busy, bus.done, seg_clk, seg_pen, seg_clrn});
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done/busy cycles expected 0", n_done);
        end
        frame = rand64();
        drive_frame(frame, -1, '0, -1);
        bad = count_bit_errs(frame, 0);
        checks++;
        if (bad != 0 || cap_q.size() != 64 || obs_done_k != T_DONE) begin
            errors++;
            $display("FAIL abort_recover got %0d bad bits, done at %0d expected 0, %0d",
                     bad, obs_done_k, T_DONE);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] frame = rand64();
        int dones[$];
        int bad;
        cap_q.delete();
        bus.seg_data = frame;
        for (int k = 0; k < 800; k++) begin
            bus.start = (k < 600);
            @(negedge clk);
            if (bus.done === 1'b1) dones.push_back(k);
        end
        bus.start = 1'b0;
        checks++;
        if (dones.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 3", dones.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dones[i] != T_DONE + i * (T_DONE + 2)) begin
                    errors++;
                    $display("FAIL b2b_done_%0d got %0d expected %0d", i, dones[i],
                             T_DONE + i * (T_DONE + 2));
                end
            end
        end
        bad = count_bit_errs(frame, 0) + count_bit_errs(frame, 64) + count_bit_errs(frame, 128);
        checks++;
        if (bad != 0 || cap_q.size() != 192) begin
            errors++;
            $display("FAIL b2b_bits got %0d bad of %0d expected 0 of 192", bad, cap_q.size());
        end
    endtask

    task automatic test_auto_refresh();
        logic [63:0] frame = rand64();
        int dones[$];
        int first_load = -1;
        logic prev_busy = 1'b0;
        int bad;
        bus.start = 1'b0;
        bus.seg_data = frame;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cap_q.delete();
        rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && prev_busy == 1'b0 && first_load < 0) first_load = k;
            prev_busy = bus.busy;
            if (bus.done === 1'b1) dones.push_back(k);
        end
        checks++;
        if (first_load != GAP - 1) begin
            errors++;
            $display("FAIL auto_first_load got edge %0d expected %0d", first_load, GAP - 1);
        end
        checks++;
        if (dones.size() < 2) begin
            errors++;
            $display("FAIL auto_done_count got %0d expected >=2", dones.size());
        end else begin
            checks++;
            if (dones[1] - dones[0] != GAP + T_DONE + 1) begin
                errors++;
                $display("FAIL auto_period got %0d expected %0d", dones[1] - dones[0],
                         GAP + T_DONE + 1);
            end
        end
        bad = count_bit_errs(frame, 0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL auto_bits got %0d bad expected 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seg_data = '0;
        @(negedge clk);
        test_reset();
`ifdef SEG_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_idle();
        test_single_frame(64'hFEDC_BA98_7654_3210);
        test_single_frame(rand64());
        test_single_frame(rand64());
        test_start_while_busy();
        test_data_change();
        test_reset_mid_shift();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_serial_tx.md
Name: seg_serial_tx

Overview:
- Serial transmitter for the 8-digit seven-segment display.
- Takes the 64-bit segment frame from the hex-to-segment encoder and shifts it bit-serially into the board's 74HC595-style shift-register chain.
- Generates the shift clock, serial data, output-enable and clear strobes, with a start/busy/done handshake toward the frame producer.

Parameters:
- FRAME_W, 64, frame width in bits; fixed at 8 digits × 8 segments.
- CLK_DIV, 2, clk cycles per seg_clk half-period; legal range 1..255.
- REFRESH_GAP, 1000, idle clk cycles between automatic frames; used only with SEG_AUTO_REFRESH_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- seg_data  in  FRAME_W  frame from the encoder; digit 0 occupies [7:0].
- busy  out  1  high from the load edge until return to IDLE.
- done  out  1  one-cycle pulse when a frame is latched.
- seg_clk  out  1  shift clock to the chain; the chain samples on the rising edge.
- seg_sout  out  1  serial data.
- seg_pen  out  1  display output enable; active high.
- seg_clrn  out  1  chain clear; active low.

Behaviour:
- Reset values, one edge after rst=1:
  - state=IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0.
  - Shift register and counters cleared.
- seg_clrn: register of ~rst; goes to 1 on the first edge with rst=0.
- rst=1 mid-frame aborts the frame immediately; no done pulse; display stays blanked.
- FSM states: IDLE, SHIFT, LATCH.
  - IDLE -> SHIFT: edge where start=1. seg_data captured into the shift register on that same edge (the load edge). busy=1 from that edge on.
  - SHIFT: 64 bits, MSB first, seg_data[63] first and seg_data[0] last. Per bit:
    - seg_clk=0 for CLK_DIV cycles with seg_sout valid.
    - Then seg_clk=1 for CLK_DIV cycles; seg_sout held stable.
    - Next bit's seg_sout updates on the same edge seg_clk returns to 0.
  - SHIFT -> LATCH: exactly 128·CLK_DIV edges after the load edge (after the 64th high phase).
  - LATCH, one cycle: done=1, seg_clk=0, seg_pen=1.
  - LATCH -> IDLE: next edge, busy=0.
- Start-to-done latency: done high in the cycle after edge load+128·CLK_DIV. With CLK_DIV=2, that is edge +256.
- seg_pen: 0 during SHIFT (blank while shifting); 1 from LATCH onward until the next load edge or reset.
- start ignored in SHIFT and LATCH; it is not queued. start held high continuously gives back-to-back frames with one IDLE cycle between them.
- seg_data changes after the load edge have no effect on the current frame.
- Bit counter: 7 bits, 0..63, no wrap beyond 63. Divider counter: 8 bits, reloads at CLK_DIV-1.

Optional Feature:
- Macro: SEG_AUTO_REFRESH_EN.
- Defined:
  - An idle counter runs in IDLE. The FSM self-starts a frame when the counter reaches REFRESH_GAP-1, or earlier if start=1.
  - The counter clears on every load edge and on reset.
  - First auto frame starts REFRESH_GAP cycles after reset release.
- Undefined: frames start only on start; no idle counter is synthesised.

Decomposition:
- Package seg_pkg:
  - SEG_FRAME_W=64, SEG_DIGITS=8.
  - State typedef seg_tx_state_t {IDLE, SHIFT, LATCH}.
  - Divider width constant SEG_DIV_W=8.
- Sub-module seg_clk_div:
  - Parameterised by CLK_DIV.
  - Outputs a phase-toggle tick and the current phase, so the FSM only consumes ticks.
  - Enabled only in SHIFT; reset to phase 0 on load edge.

Test Plan:
- Reset then idle: rst 3 cycles, release -> seg_clrn=1 after one edge; busy=0, seg_pen=0, seg_clk=0 held for 50 cycles with no start.
- Single frame: seg_data=64'hFEDC_BA98_7654_3210, CLK_DIV=2, start pulse -> capture 64 seg_sout bits on seg_clk rising edges equal to bits 63..0; done at load+256; seg_pen 0→1 at LATCH.
- Start while busy: second start at load+40 with different seg_data -> ignored; captured frame still the first value; exactly one done.
- Data change mid-frame: seg_data flipped to ~value at load+10 -> shifted bits still match the value captured at the load edge.
- Reset mid-shift: rst at load+100 -> next edge busy=0, seg_clk=0, seg_pen=0, seg_clrn=0; no done; a new frame after release completes correctly.
- SEG_AUTO_REFRESH_EN defined, REFRESH_GAP=20, start tied 0 -> frames begin every 20 idle cycles; done period = 20+256+1 cycles at CLK_DIV=2.
